// File: rtl/irq_pend_ctrl.sv
// irq_pend_ctrl
//   Interrupt pending/arbitration stage in front of the 8-to-3 priority
//   encoder. The eight raw request lines are synchronized. They are captured
//   into a sticky pending register and gated by a writable mask. The
//   highest-priority unmasked pending index (bit 7 highest) is offered on a
//   valid/ready handshake. The pending bit clears when the offer is accepted.
//
// Build option:
//   IRQ_EDGE_EN  defined   -> edge-triggered capture with lost-request counter
//                undefined -> level-triggered capture, lost_cnt tied to 0
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   irq_in     in   8  raw asynchronous request lines
//   mask_wr    in   1  load mask_din into the mask register
//   mask_din   in   8  new mask value (1 = line enabled)
//   lost_clr   in   1  synchronous clear of lost_cnt
//   vec_ready  in   1  consumer accepts vec_id when high with vec_valid
//   mask_q     out  8  current mask register
//   pend_q     out  8  current pending register (encoder input vector)
//   vec_valid  out  1  vec_id holds a valid offer
//   vec_id     out  3  offered interrupt index
//   lost_cnt   out  8  saturating count of requests lost to a pending bit
module irq_pend_ctrl #(
  parameter logic [7:0] MASK_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_din,
  input  logic       lost_clr,
  input  logic       vec_ready,
  output logic [7:0] mask_q,
  output logic [7:0] pend_q,
  output logic       vec_valid,
  output logic [2:0] vec_id,
  output logic [7:0] lost_cnt
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t     state_q;
  logic [7:0] sync1_q;
  logic [7:0] sync2_q;
  logic [7:0] set_d;
  logic [7:0] clr_d;
  logic [7:0] pend_d;
  logic [7:0] eff_d;
  logic       accept_d;

  // Index of the highest set bit; later (higher) bits overwrite lower ones.
  function automatic logic [2:0] hi_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Two-flop synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef IRQ_EDGE_EN
  logic [7:0] prev_q;
  logic       lost_hit_d;
  logic [7:0] lost_q;
  logic [7:0] lost_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 8'h00;
    else        prev_q <= sync2_q;
  end

  assign set_d = sync2_q & ~prev_q;

  // A request is lost when it hits a bit that stays pending this cycle.
  // Any number of such hits in one cycle counts once.
  assign lost_hit_d = |(set_d & pend_q & ~clr_d);

  always_comb begin
    lost_d = lost_q;
    if (lost_clr)                          lost_d = 8'h00;
    else if (lost_hit_d && lost_q != 8'hFF) lost_d = lost_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lost_q <= 8'h00;
    else        lost_q <= lost_d;
  end

  assign lost_cnt = lost_q;
`else
  logic unused_lost_clr;

  assign set_d           = sync2_q;
  assign lost_cnt        = 8'h00;
  assign unused_lost_clr = lost_clr;
`endif

  assign accept_d = vec_valid & vec_ready;
  assign clr_d    = accept_d ? (8'b1 << vec_id) : 8'h00;
  // Set is OR-ed in after the clear so a simultaneous set wins.
  assign pend_d   = (pend_q & ~clr_d) | set_d;
  assign eff_d    = pend_q & mask_q;

  // Pending and mask registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 8'h00;
      mask_q <= MASK_RESET;
    end else begin
      pend_q <= pend_d;
      if (mask_wr) mask_q <= mask_din;
    end
  end

  // Offer FSM: the offer is frozen in OFFER, so neither new higher-priority
  // requests nor mask writes can preempt it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_valid <= 1'b0;
      vec_id    <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (eff_d != 8'h00) begin
            vec_id    <= hi_index(eff_d);
            vec_valid <= 1'b1;
            state_q   <= OFFER;
          end
        end
        OFFER: begin
          if (vec_ready) begin
            vec_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pend_ctrl.sv
module tb_irq_pend_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_din;
  logic       lost_clr;
  logic       vec_ready;
  logic [7:0] mask_q;
  logic [7:0] pend_q;
  logic       vec_valid;
  logic [2:0] vec_id;
  logic [7:0] lost_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] sb[$];
  logic       acc_prev = 1'b0;

  irq_pend_ctrl #(.MASK_RESET(8'hFF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask_wr   (mask_wr),
    .mask_din  (mask_din),
    .lost_clr  (lost_clr),
    .vec_ready (vec_ready),
    .mask_q    (mask_q),
    .pend_q    (pend_q),
    .vec_valid (vec_valid),
    .vec_id    (vec_id),
    .lost_cnt  (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: every accepted offer pops one expected index, and
  // the cycle after an acceptance must not carry an offer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_prev) begin
        n_checks++;
        if (vec_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_gap: vec_valid=%b required 0 after acceptance", vec_valid);
        end
      end
      acc_prev = 1'b0;
      if (vec_valid === 1'b1 && vec_ready === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL offer_unexpected: vec_id=%0d offered, none expected", vec_id);
        end else begin
          logic [2:0] exp_id;
          exp_id = sb.pop_front();
          if (vec_id !== exp_id) begin
            n_fail++;
            $display("FAIL offer_id: vec_id=%0d required %0d", vec_id, exp_id);
          end
        end
        acc_prev = 1'b1;
      end
    end else begin
      acc_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse: the lines are high for exactly one rising edge.
  task automatic pulse_irq(input logic [7:0] v);
    irq_in = v;
    step();
    irq_in = 8'h00;
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_wr  = 1'b1;
    mask_din = v;
    step();
    mask_wr  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    irq_in = 8'h00; mask_wr = 1'b0; mask_din = 8'h00;
    lost_clr = 1'b0; vec_ready = 1'b0;
    step(); step();
    n_checks++; if (mask_q !== 8'hFF) begin n_fail++; $display("FAIL rst_mask: mask_q=%h required ff", mask_q); end
    n_checks++; if (pend_q !== 8'h00) begin n_fail++; $display("FAIL rst_pend: pend_q=%h required 00", pend_q); end
    n_checks++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: vec_valid=%b required 0", vec_valid); end
    n_checks++; if (lost_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_lost: lost_cnt=%h required 00", lost_cnt); end
    rst_n = 1'b1;
    step(); step();
    n_checks++; if (vec_valid !== 1'b0 || pend_q !== 8'h00) begin n_fail++; $display("FAIL rst_idle: vec_valid=%b pend_q=%h required 0/00", vec_valid, pend_q); end
  endtask

  task automatic test_single();
    vec_ready = 1'b1;
    sb.push_back(3'd3);
    pulse_irq(8'h08);          // edge k
    step();                    // k+1
    n_checks++; if (pend_q !== 8'h00) begin n_fail++; $display("FAIL single_k1: pend_q=%h required 00", pend_q); end
    step();                    // k+2
    n_checks++; if (pend_q !== 8'h08) begin n_fail++; $display("FAIL single_pend: pend_q=%h required 08", pend_q); end
    n_checks++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: vec_valid=%b required 0", vec_valid); end
    step();                    // k+3
    n_checks++; if (vec_valid !== 1'b1 || vec_id !== 3'd3) begin n_fail++; $display("FAIL single_offer: vec_valid=%b vec_id=%0d required 1/3", vec_valid, vec_id); end
    step();                    // k+4: accepted
    n_checks++; if (pend_q !== 8'h00 || vec_valid !== 1'b0) begin n_fail++; $display("FAIL single_clear: pend_q=%h vec_valid=%b required 00/0", pend_q, vec_valid); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL single_sb: %0d offers outstanding, required 0", sb.size()); end
  endtask

  task automatic test_priority_burst();
    vec_ready = 1'b1;
    sb.push_back(3'd7); sb.push_back(3'd5); sb.push_back(3'd2); sb.push_back(3'd0);
    pulse_irq(8'hA5);
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL burst_sb: %0d offers outstanding, required 0", sb.size()); end
    step();
    n_checks++; if (pend_q !== 8'h00 || vec_valid !== 1'b0) begin n_fail++; $display("FAIL burst_end: pend_q=%h vec_valid=%b required 00/0", pend_q, vec_valid); end
  endtask

  task automatic test_no_preempt();
    vec_ready = 1'b0;
    pulse_irq(8'h04);
    for (int i = 0; i < 10 && vec_valid !== 1'b1; i++) step();
    n_checks++; if (vec_valid !== 1'b1 || vec_id !== 3'd2) begin n_fail++; $display("FAIL hold_first: vec_valid=%b vec_id=%0d required 1/2", vec_valid, vec_id); end
    pulse_irq(8'h40);
    repeat (5) step();
    n_checks++; if (vec_valid !== 1'b1 || vec_id !== 3'd2) begin n_fail++; $display("FAIL hold_stable: vec_valid=%b vec_id=%0d required 1/2", vec_valid, vec_id); end
    n_checks++; if (pend_q !== 8'h44) begin n_fail++; $display("FAIL hold_pend: pend_q=%h required 44", pend_q); end
    sb.push_back(3'd2); sb.push_back(3'd6);
    vec_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL hold_sb: %0d offers outstanding, required 0", sb.size()); end
    step();
  endtask

  task automatic test_mask();
    vec_ready = 1'b1;
    write_mask(8'h7F);
    n_checks++; if (mask_q !== 8'h7F) begin n_fail++; $display("FAIL mask_wr: mask_q=%h required 7f", mask_q); end
    sb.push_back(3'd1);
    pulse_irq(8'h82);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    repeat (5) step();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL mask_sb1: %0d offers outstanding, required 0", sb.size()); end
    n_checks++; if (pend_q !== 8'h80 || vec_valid !== 1'b0) begin n_fail++; $display("FAIL mask_hold: pend_q=%h vec_valid=%b required 80/0", pend_q, vec_valid); end
    sb.push_back(3'd7);
    write_mask(8'hFF);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    step();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL mask_sb2: %0d offers outstanding, required 0", sb.size()); end
    n_checks++; if (pend_q !== 8'h00) begin n_fail++; $display("FAIL mask_clear: pend_q=%h required 00", pend_q); end
  endtask

  task automatic test_lost();
    vec_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pulse_irq(8'h01);
      repeat (3) step();
    end
    repeat (3) step();
    n_checks++; if (pend_q !== 8'h01) begin n_fail++; $display("FAIL lost_pend: pend_q=%h required 01", pend_q); end
`ifdef IRQ_EDGE_EN
    n_checks++; if (lost_cnt !== 8'd2) begin n_fail++; $display("FAIL lost_count: lost_cnt=%0d required 2", lost_cnt); end
    lost_clr = 1'b1; step(); lost_clr = 1'b0;
    n_checks++; if (lost_cnt !== 8'd0) begin n_fail++; $display("FAIL lost_clr: lost_cnt=%0d required 0", lost_cnt); end
    for (int p = 0; p < 300; p++) begin
      irq_in = 8'h01; step();
      irq_in = 8'h00; step();
    end
    repeat (4) step();
    n_checks++; if (lost_cnt !== 8'd255) begin n_fail++; $display("FAIL lost_sat: lost_cnt=%0d required 255", lost_cnt); end
    // Clear wins over a simultaneous loss.
    irq_in = 8'h01; step(); irq_in = 8'h00; step();
    lost_clr = 1'b1; step(); lost_clr = 1'b0;
    n_checks++; if (lost_cnt !== 8'd0) begin n_fail++; $display("FAIL lost_clr_prio: lost_cnt=%0d required 0", lost_cnt); end
    repeat (3) step();
    n_checks++; if (lost_cnt !== 8'd0) begin n_fail++; $display("FAIL lost_after_clr: lost_cnt=%0d required 0", lost_cnt); end
`else
    n_checks++; if (lost_cnt !== 8'd0) begin n_fail++; $display("FAIL lost_tied: lost_cnt=%0d required 0", lost_cnt); end
`endif
    sb.push_back(3'd0);
    vec_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    step();
    n_checks++; if (sb.size() != 0 || pend_q !== 8'h00) begin n_fail++; $display("FAIL lost_drain: outstanding=%0d pend_q=%h required 0/00", sb.size(), pend_q); end
  endtask

  task automatic test_reset_mid_offer();
    vec_ready = 1'b0;
    write_mask(8'h3C);
    pulse_irq(8'h10);
    for (int i = 0; i < 10 && vec_valid !== 1'b1; i++) step();
    n_checks++; if (vec_valid !== 1'b1 || vec_id !== 3'd4) begin n_fail++; $display("FAIL rmid_offer: vec_valid=%b vec_id=%0d required 1/4", vec_valid, vec_id); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async: vec_valid=%b required 0", vec_valid); end
    n_checks++; if (pend_q !== 8'h00 || mask_q !== 8'hFF) begin n_fail++; $display("FAIL rmid_state: pend_q=%h mask_q=%h required 00/ff", pend_q, mask_q); end
    step();
    rst_n = 1'b1;
    repeat (4) step();
    n_checks++; if (vec_valid !== 1'b0 || pend_q !== 8'h00) begin n_fail++; $display("FAIL rmid_after: vec_valid=%b pend_q=%h required 0/00", vec_valid, pend_q); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority_burst();
    test_no_preempt();
    test_mask();
    test_lost();
    test_reset_mid_offer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_pend_ctrl.md
# irq_pend_ctrl

Interrupt pending/arbitration stage that sits directly upstream of the 8-to-3 priority encoding path. It synchronizes eight raw request lines, latches them into a sticky pending register, and applies a writable mask. It offers the highest-priority unmasked pending index (bit 7 highest) as a 3-bit vector over a valid/ready handshake, and clears that pending bit when the vector is accepted.

## Interface
- MASK_RESET, 8'hFF, reset value of the mask register (1 = line enabled).

- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- irq_in  input  8  raw, asynchronous request lines.
- mask_wr  input  1  load mask_din into the mask register this cycle.
- mask_din  input  8  new mask value.
- lost_clr  input  1  synchronous clear of lost_cnt.
- vec_ready  input  1  consumer accepts vec_id when high together with vec_valid.
- mask_q  output  8  current mask register.
- pend_q  output  8  current pending register; this is the vector fed to the encoder.
- vec_valid  output  1  vec_id holds a valid offer.
- vec_id  output  3  offered interrupt index, 7..0.
- lost_cnt  output  8  saturating count of requests lost to an already-pending bit.

## Operation
- Reset values: pend_q = 0, vec_valid = 0, vec_id = 0, lost_cnt = 0, mask_q = MASK_RESET, synchronizer and history flops = 0, FSM in IDLE.
- Synchronizer: two flops per line (s1, s2), followed by a history flop s_prev that registers s2.
- Set condition per bit i:
  - Edge mode: s2[i] & ~s_prev[i].
  - Level mode: s2[i].
- Pending update per bit:
  - pend[i] is set when its set condition is true.
  - pend[i] is cleared when its vector is accepted.
  - If set and clear occur in the same cycle, set wins.
- eff = pend_q & mask_q. Masked pending bits stay pending indefinitely.
- FSM IDLE:
  - If eff != 0, register vec_id = index of the highest set bit of eff, set vec_valid = 1, and go to OFFER.
  - Otherwise stay in IDLE.
- FSM OFFER:
  - vec_id and vec_valid are held stable until vec_valid & vec_ready.
  - There is no preemption by higher-priority arrivals or by mask changes.
  - On acceptance: clear pend[vec_id], set vec_valid = 0, and return to IDLE.
- Mask write: mask_q <= mask_din on the clock edge where mask_wr is high. The new mask affects selection from the following cycle only.
- lost_cnt:
  - Increments by 1 when a set condition hits a bit that is already pending and is not being cleared that cycle.
  - Multiple simultaneous losses in one cycle still count as 1.
  - Saturates at 255.
  - lost_clr takes priority over an increment in the same cycle.
- Reset mid-offer: all state returns to reset values immediately and the offer is dropped without any clear handshake.

## Timing
- irq_in high, first sampled at edge k: s1 at k, s2 at k+1, pend_q bit set at k+2, vec_valid rises at k+3 (FSM starts in IDLE).
- Acceptance at edge a: pend bit clears and vec_valid falls at a. The earliest next vec_valid is a+1, so there is at least one idle cycle between offers.
- The consumer may hold vec_ready high permanently. Sustained throughput is then one vector per 2 cycles.
- An irq_in pulse must be at least 1 clk high to be captured. Shorter pulses may be lost.

## Configuration
- IRQ_EDGE_EN defined: edge-triggered capture as described. A line held high produces exactly one pending set per rising edge. lost_cnt is active.
- IRQ_EDGE_EN undefined: level-triggered capture. A line still high after acceptance re-pends one cycle later. The s_prev flops are removed, and lost_cnt is tied to 0 and never increments.

## Test plan
- Reset with irq_in = 8'h00: mask_q = 8'hFF, pend_q = 0, vec_valid = 0, lost_cnt = 0. Assert rst_n low mid-OFFER: vec_valid drops to 0 asynchronously.
- Single edge on irq_in[3], vec_ready = 1: pend_q = 8'h08 at k+2, vec_valid with vec_id = 3 at k+3, pend_q = 0 after acceptance.
- irq_in = 8'hA5 together, vec_ready = 1: vec_id sequence is 7, 5, 2, 0, each offer separated by one idle cycle.
- Offer of id 2 held with vec_ready = 0, then raise irq_in[6]: vec_id stays 2 until accepted, and the next offer is 6.
- mask_din = 8'h7F written, then irq_in[7] and irq_in[1] raised: offer 1 only; pend_q[7] stays 1. Rewrite mask to 8'hFF: offer 7 follows.
- Edge build (IRQ_EDGE_EN): pulse irq_in[0] three times while vec_ready = 0 and pend[0] is set: lost_cnt = 2. Pulse lost_clr: lost_cnt = 0. Drive 300 lost events: lost_cnt saturates at 255.
